// File: rtl/alu_seq_ctrl.sv
// Multi-byte sequencer that drives an 8-bit ALU one byte per cycle, chains the
// shift/carry bit between bytes, assembles the wide result and pulses done.
package alu_seq_pkg;
  typedef enum logic [1:0] {
    CMD_ADD   = 2'b00,
    CMD_XOR   = 2'b01,
    CMD_SHR   = 2'b10,
    CMD_CMPEQ = 2'b11
  } cmd_e;

  // ALU OP encodings shared with the ALU definitions
  localparam logic [3:0] kADD = 4'h0;
  localparam logic [3:0] kXOR = 4'h2;
  localparam logic [3:0] kLRS = 4'h5;
  localparam logic [3:0] kENQ = 4'h9;
endpackage

module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          cmd,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  output logic [8*NBYTES-1:0] res_out,
  output logic                cout,
  output logic                flag_out,
  output logic                busy,
  output logic                done,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_op,
  output logic                alu_t,
  output logic                alu_sc_in,
  input  logic [7:0]          alu_out,
  input  logic                alu_sc_out,
  input  logic                alu_zero
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            carry_q, carry_d, flag_q, flag_d;
  logic [IW-1:0]   idx_q, idx_d, sel;

  // SHR walks from the MSB byte down so each byte's bit0 can feed the next
  always_comb sel = (cmd_q == CMD_SHR) ? (LAST_IDX - idx_q) : idx_q;

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = kADD;
    alu_t     = 1'b0;
    alu_sc_in = 1'b0;
    if (state_q == S_RUN) begin
      alu_a = a_q[sel*8 +: 8];
      alu_b = b_q[sel*8 +: 8];
      case (cmd_q)
        CMD_ADD: begin
          alu_op    = kADD;
          alu_sc_in = carry_q;
        end
        CMD_XOR: alu_op = kXOR;
        CMD_SHR: begin
          alu_op    = kLRS;
          alu_t     = 1'b1;
          alu_sc_in = carry_q;
        end
        default: alu_op = kENQ;
      endcase
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    flag_d  = flag_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          cmd_d   = cmd_e'(cmd);
          carry_d = cin;
          res_d   = '0;
          idx_d   = '0;
          flag_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cmd_q != CMD_CMPEQ) res_d[sel*8 +: 8] = alu_out;
        carry_d = (cmd_q == CMD_CMPEQ) ? 1'b0 : alu_sc_out;
        flag_d  = flag_q & ((cmd_q == CMD_CMPEQ) ? alu_out[0] : alu_zero);
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        if (abort)                  state_d = S_IDLE;
        else if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      flag_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      flag_q  <= flag_d;
      idx_q   <= idx_d;
    end
  end

  assign res_out  = res_q;
  assign cout     = carry_q;
  assign flag_out = flag_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
endmodule
